// File: rtl/rom_load_ctrl.sv
// ROM download router: one ioctl byte -> one region write; 1 cycle + ack delay, ioctl_wait stalls the loader until rgn_ack.
// Optional ROM_LOAD_CHECKSUM_EN adds a 16-bit additive checksum of region-written bytes (otherwise checksum is tied to 0).
module rom_load_ctrl #(
  parameter logic [24:0] R1_BASE  = 25'h0C000,
  parameter logic [24:0] R2_BASE  = 25'h1C000,
  parameter logic [24:0] R3_BASE  = 25'h24000,
  parameter logic [24:0] TOP      = 25'h26000,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [3:0]  rgn_we,
  output logic [15:0] rgn_addr,
  output logic [7:0]  rgn_data,
  input  logic [3:0]  rgn_ack,
  output logic        core_hold,
  output logic [7:0]  mod,
  output logic        load_done,
  output logic        overflow,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DRAIN, DONE} state_t;

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);

  state_t        state_q;
  logic [3:0]    rgn_we_q;
  logic [15:0]   rgn_addr_q;
  logic [7:0]    rgn_data_q;
  logic          ioctl_wait_q;
  logic          core_hold_q;
  logic [7:0]    mod_q;
  logic          load_done_q;
  logic          overflow_q;
  logic [CW-1:0] cnt_q;

  logic [3:0]    dec_we;
  logic [15:0]   dec_addr;
  logic          start_dl;
  logic          byte_wr;
  logic          mod_wr;
  logic          ack_hit;

  // Region offsets fit in 16 bits, so subtracting only the low halves is exact.
  always_comb begin
    dec_we   = 4'b0000;
    dec_addr = 16'h0000;
    if (ioctl_addr < R1_BASE) begin
      dec_we   = 4'b0001;
      dec_addr = ioctl_addr[15:0];
    end else if (ioctl_addr < R2_BASE) begin
      dec_we   = 4'b0010;
      dec_addr = ioctl_addr[15:0] - R1_BASE[15:0];
    end else if (ioctl_addr < R3_BASE) begin
      dec_we   = 4'b0100;
      dec_addr = ioctl_addr[15:0] - R2_BASE[15:0];
    end else if (ioctl_addr < TOP) begin
      dec_we   = 4'b1000;
      dec_addr = ioctl_addr[15:0] - R3_BASE[15:0];
    end
  end

  assign start_dl = ioctl_download && (ioctl_index == 8'd0);
  assign byte_wr  = ioctl_wr && (ioctl_index == 8'd0) && !ioctl_wait_q;
  assign mod_wr   = ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0);
  assign ack_hit  = |(rgn_ack & rgn_we_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rgn_we_q     <= 4'b0000;
      rgn_addr_q   <= 16'h0000;
      rgn_data_q   <= 8'h00;
      ioctl_wait_q <= 1'b0;
      core_hold_q  <= 1'b1;
      mod_q        <= 8'hFF;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (mod_wr) mod_q <= ioctl_dout;
      case (state_q)
        IDLE, DONE: begin
          if (start_dl) begin
            state_q     <= ACCEPT;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            core_hold_q <= 1'b1;
          end
        end
        ACCEPT: begin
          if (!ioctl_download) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else if (byte_wr) begin
            if (|dec_we) begin
              rgn_we_q     <= dec_we;
              rgn_addr_q   <= dec_addr;
              rgn_data_q   <= ioctl_dout;
              ioctl_wait_q <= 1'b1;
              state_q      <= WRITE;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          // A download that ended mid-write goes straight to DRAIN once the write lands.
          if (ack_hit) begin
            rgn_we_q     <= 4'b0000;
            ioctl_wait_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ioctl_download ? ACCEPT : DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            core_hold_q <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= 16'h0000;
    end else if (((state_q == IDLE) || (state_q == DONE)) && start_dl) begin
      checksum_q <= 16'h0000;
    end else if ((state_q == WRITE) && ack_hit) begin
      checksum_q <= checksum_q + {8'h00, rgn_data_q};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_wait = ioctl_wait_q;
  assign rgn_we     = rgn_we_q;
  assign rgn_addr   = rgn_addr_q;
  assign rgn_data   = rgn_data_q;
  assign core_hold  = core_hold_q;
  assign mod        = mod_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: expected region writes queued at drive time, popped when rgn_we appears.
module tb_rom_load_ctrl;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

`ifdef ROM_LOAD_CHECKSUM_EN
  localparam logic [15:0] SUM257 = 16'hFFFF;
`else
  localparam logic [15:0] SUM257 = 16'h0000;
`endif

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [3:0]  rgn_we;
  logic [15:0] rgn_addr;
  logic [7:0]  rgn_data;
  logic [3:0]  rgn_ack;
  logic        core_hold;
  logic [7:0]  mod;
  logic        load_done;
  logic        overflow;
  logic [15:0] checksum;

  wr_t         exp_q[$];
  int          total;
  int          bad;
  logic [15:0] exp_sum;

  rom_load_ctrl dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .rgn_we        (rgn_we),
    .rgn_addr      (rgn_addr),
    .rgn_data      (rgn_data),
    .rgn_ack       (rgn_ack),
    .core_hold     (core_hold),
    .mod           (mod),
    .load_done     (load_done),
    .overflow      (overflow),
    .checksum      (checksum)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t model(input logic [24:0] a, input logic [7:0] d);
    wr_t r;
    logic [24:0] off;
    r.data = d;
    r.we   = 4'b0000;
    off    = 25'd0;
    if (a < 25'h0C000) begin
      r.we = 4'b0001; off = a;
    end else if (a < 25'h1C000) begin
      r.we = 4'b0010; off = a - 25'h0C000;
    end else if (a < 25'h24000) begin
      r.we = 4'b0100; off = a - 25'h1C000;
    end else if (a < 25'h26000) begin
      r.we = 4'b1000; off = a - 25'h24000;
    end
    r.addr = off[15:0];
    return r;
  endfunction

  // One index-0 byte; ack for the selected region after dly cycles, other ack bits driven meanwhile.
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d, input int dly);
    wr_t e;
    int  wc;
    exp_q.push_back(model(a, d));
    ioctl_index = 8'd0; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    e = exp_q.pop_front();
    check("rgn_we", {28'd0, rgn_we}, {28'd0, e.we});
    check("rgn_addr", {16'd0, rgn_addr}, {16'd0, e.addr});
    check("rgn_data", {24'd0, rgn_data}, {24'd0, e.data});
    wc = ioctl_wait ? 1 : 0;
    for (int i = 0; i < dly; i++) begin
      rgn_ack = ~e.we;
      if (i == 0) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'h00100; ioctl_dout = 8'h77;
      end
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check("we_held", {28'd0, rgn_we}, {28'd0, e.we});
      if (ioctl_wait) wc++;
    end
    rgn_ack = e.we;
    @(negedge clk_sys);
    rgn_ack = 4'b0000;
    check("we_drop", {28'd0, rgn_we}, 32'd0);
    check("wait_drop", {31'd0, ioctl_wait}, 32'd0);
    check("wait_cycles", 32'(wc), 32'(dly + 1));
`ifdef ROM_LOAD_CHECKSUM_EN
    exp_sum = exp_sum + {8'h00, d};
`endif
  endtask

  initial begin
    wr_t e;
    int  hc;
    total = 0; bad = 0; exp_sum = 16'h0000;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; rgn_ack = 4'b0000;
    repeat (2) @(negedge clk_sys);

    check("rst_we", {28'd0, rgn_we}, 32'd0);
    check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_sum", {16'd0, checksum}, 32'd0);
    check("rst_mod", {24'd0, mod}, 32'hFF);
    check("rst_addr", {16'd0, rgn_addr}, 32'd0);
    check("rst_data", {24'd0, rgn_data}, 32'd0);

    reset_n = 1'b1;
    @(negedge clk_sys);
    check("hold_idle", {31'd0, core_hold}, 32'd1);
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    @(negedge clk_sys);
    check("start_hold", {31'd0, core_hold}, 32'd1);

    exp_q.push_back('{we: 4'b0010, addr: 16'h0005, data: 8'hA5});
    ioctl_addr = 25'h0C005; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    e = exp_q.pop_front();
    check("r1_we", {28'd0, rgn_we}, {28'd0, e.we});
    check("r1_addr", {16'd0, rgn_addr}, {16'd0, e.addr});
    hc = 0;
    for (int i = 0; i < 8 && ioctl_wait; i++) begin
      hc++;
      rgn_ack = (i == 3) ? 4'b0010 : 4'b0000;
      @(negedge clk_sys);
    end
    rgn_ack = 4'b0000;
    check("r1_wait_cycles", 32'(hc), 32'd4);
    check("r1_we_drop", {28'd0, rgn_we}, 32'd0);
`ifdef ROM_LOAD_CHECKSUM_EN
    exp_sum = exp_sum + 16'h00A5;
`endif

    write_byte(25'h00010, 8'h3C, 0);
    write_byte(25'h1BFFF, 8'h81, 2);
    write_byte(25'h1C123, 8'h42, 1);
    write_byte(25'h25FFF, 8'hE7, 3);
    write_byte(25'h0BFFF, 8'h18, 0);
    check("sum_mid", {16'd0, checksum}, {16'd0, exp_sum});

    ioctl_addr = 25'h26000; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("ovf_we", {28'd0, rgn_we}, 32'd0);
    check("ovf_wait", {31'd0, ioctl_wait}, 32'd0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_sum", {16'd0, checksum}, {16'd0, exp_sum});

    ioctl_index = 8'd1; ioctl_addr = 25'd0; ioctl_dout = 8'h05; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("mod_load", {24'd0, mod}, 32'h05);
    check("mod_wait", {31'd0, ioctl_wait}, 32'd0);
    check("mod_we", {28'd0, rgn_we}, 32'd0);
    check("mod_hold", {31'd0, core_hold}, 32'd1);
    ioctl_addr = 25'd1; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("mod_nz_addr", {24'd0, mod}, 32'h05);
    check("mod_sum", {16'd0, checksum}, {16'd0, exp_sum});
    write_byte(25'h24010, 8'h6B, 1);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    exp_q.push_back(model(25'h00020, 8'h5A));
    ioctl_index = 8'd0; ioctl_addr = 25'h00020; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    e = exp_q.pop_front();
    check("dl_fall_we", {28'd0, rgn_we}, {28'd0, e.we});
    repeat (2) @(negedge clk_sys);
    check("dl_fall_held", {28'd0, rgn_we}, 32'b0001);
    check("dl_fall_wait", {31'd0, ioctl_wait}, 32'd1);
    rgn_ack = e.we;
    @(negedge clk_sys);
    rgn_ack = 4'b0000;
    check("dl_fall_done", {28'd0, rgn_we}, 32'd0);
    check("drain_no_done", {31'd0, load_done}, 32'd0);
`ifdef ROM_LOAD_CHECKSUM_EN
    exp_sum = exp_sum + 16'h005A;
`endif
    hc = 0;
    for (int i = 0; i < 40 && core_hold; i++) begin
      hc++;
      @(negedge clk_sys);
    end
    check("drain_cycles", 32'(hc), 32'd16);
    check("load_done", {31'd0, load_done}, 32'd1);
    check("sum_final", {16'd0, checksum}, {16'd0, exp_sum});

    ioctl_download = 1'b1; ioctl_index = 8'd0;
    @(negedge clk_sys);
    check("restart_ovf", {31'd0, overflow}, 32'd0);
    check("restart_done", {31'd0, load_done}, 32'd0);
    check("restart_hold", {31'd0, core_hold}, 32'd1);
    check("restart_sum", {16'd0, checksum}, 32'd0);
    exp_sum = 16'h0000;
    for (int i = 0; i < 257; i++) write_byte(25'(i), 8'hFF, 0);
    check("sum_257", {16'd0, checksum}, {16'd0, SUM257});
    check("sum_257_model", {16'd0, checksum}, {16'd0, exp_sum});
    ioctl_download = 1'b0;
    for (int i = 0; i < 40 && !load_done; i++) @(negedge clk_sys);
    check("done2", {31'd0, load_done}, 32'd1);

    ioctl_download = 1'b1; ioctl_index = 8'd2;
    @(negedge clk_sys);
    ioctl_addr = 25'h00010; ioctl_dout = 8'h11; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("idx2_we", {28'd0, rgn_we}, 32'd0);
    check("idx2_wait", {31'd0, ioctl_wait}, 32'd0);
    check("idx2_hold", {31'd0, core_hold}, 32'd0);
    check("idx2_done", {31'd0, load_done}, 32'd1);
    ioctl_download = 1'b0;
    @(negedge clk_sys);

    ioctl_download = 1'b1; ioctl_index = 8'd0;
    @(negedge clk_sys);
    ioctl_addr = 25'h0C010; ioctl_dout = 8'h3E; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("rstw_we", {28'd0, rgn_we}, 32'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_we0", {28'd0, rgn_we}, 32'd0);
    check("rstw_wait0", {31'd0, ioctl_wait}, 32'd0);
    check("rstw_mod", {24'd0, mod}, 32'hFF);
    check("rstw_hold", {31'd0, core_hold}, 32'd1);
    ioctl_download = 1'b0;
    rgn_ack = 4'b1111;
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("post_rst_we", {28'd0, rgn_we}, 32'd0);
    end
    rgn_ack = 4'b0000;
    check("post_rst_hold", {31'd0, core_hold}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameters SHALL be: R1_BASE 25'h0C000, first byte of region 1; R2_BASE 25'h1C000, first byte of region 2; R3_BASE 25'h24000, first byte of region 3; TOP 25'h26000, first byte past region 3; HOLD_CYC 16, core-hold cycles after download end.
REQ-002 Ports SHALL be, in this order:
clk_sys  in  1  sole clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
ioctl_download  in  1  download active.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_index  in  8  0 = ROM image, 1 = game-select byte.
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  byte data.
ioctl_wait  out  1  stall to the loader.
rgn_we  out  4  one-hot region write strobe.
rgn_addr  out  16  region-relative address.
rgn_data  out  8  write data.
rgn_ack  in  4  per-region write-complete acknowledge.
core_hold  out  1  board/sound reset request.
mod  out  8  game select.
load_done  out  1  ROM image fully loaded.
overflow  out  1  sticky: byte dropped at or above TOP.
checksum  out  16  additive sum of accepted bytes.

Function
REQ-003 The FSM SHALL have states IDLE, ACCEPT, WRITE, DRAIN and DONE.
REQ-004 IDLE -> ACCEPT SHALL occur on ioctl_download=1 with ioctl_index=0; this clears load_done, overflow and checksum and asserts core_hold in the same cycle.
REQ-005 In ACCEPT, an ioctl_wr with index 0 SHALL be decoded as follows: addr<R1_BASE -> region 0; <R2_BASE -> 1; <R3_BASE -> 2; <TOP -> 3.
REQ-006 rgn_addr SHALL equal ioctl_addr minus the region base, truncated to 16 bits.
REQ-007 A decoded byte SHALL register rgn_addr and rgn_data, assert ioctl_wait the next cycle and enter WRITE.
REQ-008 In WRITE, exactly one rgn_we bit SHALL be high; it stays high until the matching rgn_ack bit is sampled high, ack in the first WRITE cycle included.
REQ-009 On ack, rgn_we and ioctl_wait SHALL drop on the next edge and the FSM SHALL return to ACCEPT; write latency is 1 cycle plus ack delay.
REQ-010 rgn_ack bits for non-selected regions SHALL be ignored.
REQ-011 A byte at or above TOP SHALL be dropped: no rgn_we, no ioctl_wait, overflow set sticky.
REQ-012 An ioctl_wr arriving while ioctl_wait=1 SHALL be ignored; the loader is held off by ioctl_wait.
REQ-013 ioctl_download falling in ACCEPT SHALL enter DRAIN.
REQ-014 ioctl_download falling in WRITE SHALL complete the pending write first, then enter DRAIN.
REQ-015 DRAIN SHALL count HOLD_CYC cycles with core_hold=1, then enter DONE with core_hold=0 and load_done=1.
REQ-016 DONE SHALL behave as IDLE; a new index-0 download restarts at REQ-004.
REQ-017 An ioctl_wr with index 1 and ioctl_addr=0 SHALL load mod in any state, with no ioctl_wait and no core_hold effect.
REQ-018 A write with index 1 and a nonzero address SHALL be ignored.
REQ-019 Downloads with any other index SHALL be ignored entirely.

Reset
REQ-020 reset_n low SHALL immediately force: FSM IDLE; rgn_we 0; ioctl_wait 0; core_hold 1; load_done 0; overflow 0; checksum 0; mod 8'hFF; rgn_addr and rgn_data 0.
REQ-021 core_hold SHALL stay 1 after reset until the first DRAIN completes.
REQ-022 Reset asserted mid-WRITE SHALL abandon the write without any further rgn_we.

Configuration
REQ-023 With ROM_LOAD_CHECKSUM_EN defined, checksum SHALL add each byte written to a region (zero-extended, mod 2^16) on its ack cycle.
REQ-024 Dropped bytes and mod-select bytes SHALL NOT contribute to checksum.
REQ-025 Without ROM_LOAD_CHECKSUM_EN, checksum SHALL be constant 16'h0000 and no adder SHALL be synthesized.

Verification
REQ-026 Reset, then index-0 download; wr addr 25'h0C005 data 8'hA5, rgn_ack[1] after 3 cycles -> rgn_we=4'b0010, rgn_addr=16'h0005, ioctl_wait high exactly 4 cycles.
REQ-027 Byte at addr 25'h26000 -> no rgn_we, ioctl_wait stays 0, overflow=1 until the next download start.
REQ-028 ioctl_download falls while WRITE is waiting on ack -> write completes, then core_hold stays high 16 cycles, then load_done=1.
REQ-029 Index-1 wr at addr 0 with data 8'h05 mid-load -> mod=8'h05, region traffic and ioctl_wait unaffected.
REQ-030 reset_n pulsed low during WRITE -> rgn_we and ioctl_wait 0 asynchronously, mod=8'hFF, core_hold=1.
REQ-031 With ROM_LOAD_CHECKSUM_EN, load bytes 8'hFF x 257 -> checksum=16'hFFFF (257*255=65535); without the macro -> 16'h0000.
